// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule.
// Loads the round-NR key and streams round keys NR..0 over a valid/ready
// handshake, deriving each earlier key from the current one with a single
// shared 32-bit ByteSub instance.
// Optional build macro: INV_KS_PREEXPAND_EN -- key_in is the cipher key and
// the round-NR key is first produced by a forward expansion (EXPAND state).

module aes_sbox_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      if (x[7]) begin
        x = {x[6:0], 1'b0} ^ 8'h1b;
      end else begin
        x = {x[6:0], 1'b0};
      end
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (b^254, 0 maps to 0) then affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(b, b);
    x3   = gf_mul(x2, b);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Substitute all four bytes of the word
  always_comb begin
    word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
              sbox(word_i[15:8]),  sbox(word_i[7:0])};
  end

endmodule

module inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         start_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic         hs_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  iw1_s, iw2_s, iw3_s, iw0_s;
  logic [31:0]  sbox_in_s, sbox_out_s;
  logic [127:0] inv_key_s;

`ifdef INV_KS_PREEXPAND_EN
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  fw0_s, fw1_s, fw2_s, fw3_s;
  logic [127:0] fwd_key_s;
`endif

  // Round constant in the top byte of the word; 0 outside 1..10
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign hs_s = valid_q & rk_ready;
  assign w0_s = key_q[127:96];
  assign w1_s = key_q[95:64];
  assign w2_s = key_q[63:32];
  assign w3_s = key_q[31:0];

  // Backward step: recover w1..w3 of the previous round, then w0 via ByteSub
  always_comb begin
    iw3_s = w3_s ^ w2_s;
    iw2_s = w2_s ^ w1_s;
    iw1_s = w1_s ^ w0_s;
  end

  // Select the ByteSub operand: RotWord of w3 when expanding forward, of w3' otherwise
  always_comb begin
`ifdef INV_KS_PREEXPAND_EN
    if (state_q == ST_EXPAND) begin
      sbox_in_s = {w3_s[23:0], w3_s[31:24]};
    end else begin
      sbox_in_s = {iw3_s[23:0], iw3_s[31:24]};
    end
`else
    sbox_in_s = {iw3_s[23:0], iw3_s[31:24]};
`endif
  end

  aes_sbox_word u_sbox (
    .word_i (sbox_in_s),
    .word_o (sbox_out_s)
  );

  // Assemble the previous round key
  always_comb begin
    iw0_s     = w0_s ^ sbox_out_s ^ {rcon(round_q), 24'h000000};
    inv_key_s = {iw0_s, iw1_s, iw2_s, iw3_s};
  end

`ifdef INV_KS_PREEXPAND_EN
  // Forward step used while building the round-NR key from the cipher key
  always_comb begin
    fw0_s     = w0_s ^ sbox_out_s ^ {rcon(cnt_q), 24'h000000};
    fw1_s     = w1_s ^ fw0_s;
    fw2_s     = w2_s ^ fw1_s;
    fw3_s     = w3_s ^ fw2_s;
    fwd_key_s = {fw0_s, fw1_s, fw2_s, fw3_s};
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef INV_KS_PREEXPAND_EN
          state_d = ST_EXPAND;
`else
          state_d = ST_EMIT;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef INV_KS_PREEXPAND_EN
      ST_EXPAND: begin
        if (cnt_q == 4'(NR)) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_EXPAND;
        end
      end
`endif
      ST_EMIT: begin
        if (hs_s && (round_q == 4'd0)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the key, round index, valid and done registers
  always_comb begin
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef INV_KS_PREEXPAND_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'(NR);
`ifdef INV_KS_PREEXPAND_EN
          cnt_d   = 4'd1;
          valid_d = 1'b0;
`else
          valid_d = 1'b1;
`endif
        end else begin
          valid_d = 1'b0;
        end
      end
`ifdef INV_KS_PREEXPAND_EN
      ST_EXPAND: begin
        key_d = fwd_key_s;
        if (cnt_q == 4'(NR)) begin
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      ST_EMIT: begin
        if (hs_s) begin
          if (round_q == 4'd0) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d   = inv_key_s;
            round_d = round_q - 4'd1;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset clears any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= 128'h0;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef INV_KS_PREEXPAND_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef INV_KS_PREEXPAND_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Output decode from registered state
  always_comb begin
    start_ready = (state_q == ST_IDLE);
    rk_valid    = valid_q;
    rk_data     = key_q;
    rk_round    = round_q;
    rk_last     = valid_q & (round_q == 4'd0);
    done        = done_q;
  end

endmodule
